// File: rtl/aes_dec_round_ctrl.sv
// Round sequencer for an iterative AES inverse cipher. Inverse SubBytes/ShiftRows,
// InvMixColumns and the round-key store are external; this block sequences them.
module aes_dec_round_ctrl #(
  parameter int unsigned SUB_LAT = 2,
  parameter int unsigned NR      = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         iStart,
  input  logic [127:0] iBlockIn,
  output logic [3:0]   oKeyAddr,
  input  logic [127:0] iKeyData,
  output logic [127:0] oSubIn,
  input  logic [127:0] iSubOut,
  output logic [127:0] oMixIn,
  input  logic [127:0] iMixOut,
  output logic         oBusy,
  output logic         oDone,
  output logic [127:0] oBlockOut
);

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned WAIT_W = (SUB_LAT < 1) ? 1 : $clog2(SUB_LAT + 1);

  localparam logic [ADDR_W-1:0] LAST_KEY  = ADDR_W'(NR);
  localparam logic [ADDR_W-1:0] FIRST_RND = ADDR_W'(NR - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(SUB_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MIX  = 2'd2
  } fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [BLK_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0] round_q, round_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [BLK_W-1:0]  out_d;
  logic              done_d;
  logic              busy_d;
  logic [ADDR_W-1:0] key_d;

  assign oSubIn = data_q;
  assign oMixIn = data_q;

  // Next-state and next-output logic; the sub-stage result is only consumed at its valid point
  always_comb begin
    fsm_d   = fsm_q;
    data_d  = data_q;
    round_d = round_q;
    wait_d  = wait_q;
    out_d   = oBlockOut;
    done_d  = 1'b0;

    unique case (fsm_q)
      IDLE: begin
        if (iStart) begin
          data_d  = iBlockIn ^ iKeyData;
          round_d = FIRST_RND;
          wait_d  = '0;
          fsm_d   = SUB;
        end
      end
      SUB: begin
        if (wait_q == WAIT_MAX) begin
          wait_d = '0;
          if (round_q != '0) begin
            data_d = iSubOut ^ iKeyData;
            fsm_d  = MIX;
          end else begin
            out_d  = iSubOut ^ iKeyData;
            done_d = 1'b1;
            fsm_d  = IDLE;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      MIX: begin
        data_d  = iMixOut;
        round_d = round_q - ADDR_W'(1);
        fsm_d   = SUB;
      end
      default: fsm_d = IDLE;
    endcase

    // Key address and busy are registered copies of what the next state will present
    busy_d = (fsm_d != IDLE);
    key_d  = (fsm_d == IDLE) ? LAST_KEY : round_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      data_q    <= '0;
      round_q   <= '0;
      wait_q    <= '0;
      oBlockOut <= '0;
      oDone     <= 1'b0;
      oBusy     <= 1'b0;
      oKeyAddr  <= LAST_KEY;
    end else begin
      fsm_q     <= fsm_d;
      data_q    <= data_d;
      round_q   <= round_d;
      wait_q    <= wait_d;
      oBlockOut <= out_d;
      oDone     <= done_d;
      oBusy     <= busy_d;
      oKeyAddr  <= key_d;
    end
  end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: surrounds two instances (SUB_LAT 2 and 3) with a
// behavioural key store, a latency-accurate inverse sub stage and InvMixColumns.
module tb_aes_dec_round_ctrl;

  localparam int SL   = 2;
  localparam int SL3  = 3;
  localparam int NRND = 10;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] rk       [16];

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start, start3;
  logic [127:0] blk, blk3;
  logic [3:0]   key_addr, key_addr3;
  logic [127:0] key_data, key_data3, sub_in, sub_in3, sub_out, sub_out3;
  logic [127:0] mix_in, mix_in3, mix_out, mix_out3, block_out, block_out3;
  logic         busy, busy3, done, done3;
  logic [127:0] pipe  [SL];
  logic [127:0] pipe3 [SL3];

  always #5 clk = ~clk;

  // ---------------- GF(2^8) and AES helpers ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = r + 4 * ((c - r + 4) % 4);
        o[127-8*(r+4*c) -: 8] = inv_sbox[s[127-8*src -: 8]];
      end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

  // Textbook inverse cipher over the current key schedule
  function automatic logic [127:0] aes_decrypt(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[NRND];
    for (int r = NRND - 1; r >= 1; r--) s = inv_mix(inv_shift_sub(s) ^ rk[r]);
    return inv_shift_sub(s) ^ rk[0];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, rr, s;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      rr = inv; s = inv;
      for (int k = 0; k < 4; k++) begin
        rr = {rr[6:0], rr[7]};
        s  = s ^ rr;
      end
      s = s ^ 8'h63;
      sbox[x]  = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= NRND) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else           rk[r] = '0;
    end
  endtask

  // ---------------- external datapath models ----------------
  assign key_data  = rk[key_addr];
  assign key_data3 = rk[key_addr3];
  assign mix_out   = inv_mix(mix_in);
  assign mix_out3  = inv_mix(mix_in3);
  assign sub_out   = pipe[SL-1];
  assign sub_out3  = pipe3[SL3-1];

  always @(posedge clk) begin
    pipe[0] <= inv_shift_sub(sub_in);
    for (int i = 1; i < SL; i++) pipe[i] <= pipe[i-1];
    pipe3[0] <= inv_shift_sub(sub_in3);
    for (int i = 1; i < SL3; i++) pipe3[i] <= pipe3[i-1];
  end

  aes_dec_round_ctrl #(.SUB_LAT(SL), .NR(NRND)) dut (
    .clk(clk), .rst_n(rst_n), .iStart(start), .iBlockIn(blk),
    .oKeyAddr(key_addr), .iKeyData(key_data), .oSubIn(sub_in), .iSubOut(sub_out),
    .oMixIn(mix_in), .iMixOut(mix_out), .oBusy(busy), .oDone(done), .oBlockOut(block_out));

  aes_dec_round_ctrl #(.SUB_LAT(SL3), .NR(NRND)) dut3 (
    .clk(clk), .rst_n(rst_n), .iStart(start3), .iBlockIn(blk3),
    .oKeyAddr(key_addr3), .iKeyData(key_data3), .oSubIn(sub_in3), .iSubOut(sub_out3),
    .oMixIn(mix_in3), .iMixOut(mix_out3), .oBusy(busy3), .oDone(done3), .oBlockOut(block_out3));

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts one block (accepted on the next edge) and returns at its oDone cycle
  task automatic run_block(input logic [127:0] ct, output logic [127:0] res,
                           output int dcyc, output int bcyc, output logic busy_at_done);
    start = 1'b1; blk = ct;
    step();
    start = 1'b0;
    dcyc = 0; bcyc = 0; busy_at_done = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      if (done) begin
        dcyc = c; busy_at_done = busy;
        break;
      end
      if (busy) bcyc++;
      step();
    end
    res = block_out;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    total++; if (done !== 1'b0)         begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (busy !== 1'b0)         begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (key_addr !== 4'(NRND)) begin bad++; $display("FAIL reset_key_addr: got %0d want %0d", key_addr, NRND); end
    total++; if (block_out !== '0)      begin bad++; $display("FAIL reset_block_out: got %h want 0", block_out); end
    total++; if (sub_in !== '0)         begin bad++; $display("FAIL reset_sub_in: got %h want 0", sub_in); end
    step(); step();
    rst_n = 1'b1;
    step();
    total++; if (busy !== 1'b0 || key_addr !== 4'(NRND) || key_addr3 !== 4'(NRND)) begin
      bad++; $display("FAIL idle_after_reset: busy %b key %0d key3 %0d want 0/%0d/%0d", busy, key_addr, key_addr3, NRND, NRND);
    end
  endtask

  task automatic test_fips();
    logic [127:0] res; int dc, bc; logic bd; int extra;
    run_block(FIPS_CT, res, dc, bc, bd);
    total++; if (dc != (NRND-1)*(SL+2)+SL+2) begin bad++; $display("FAIL fips_done_cycle: got %0d want %0d", dc, (NRND-1)*(SL+2)+SL+2); end
    total++; if (bc != (NRND-1)*(SL+2)+SL+1) begin bad++; $display("FAIL fips_busy_cycles: got %0d want %0d", bc, (NRND-1)*(SL+2)+SL+1); end
    total++; if (bd !== 1'b0)     begin bad++; $display("FAIL fips_busy_at_done: got %b want 0", bd); end
    total++; if (res !== FIPS_PT) begin bad++; $display("FAIL fips_plaintext: got %h want %h", res, FIPS_PT); end
    extra = 0;
    repeat (5) begin step(); if (done) extra++; end
    total++; if (extra != 0) begin bad++; $display("FAIL fips_single_pulse: got %0d extra pulses want 0", extra); end
    total++; if (block_out !== FIPS_PT) begin bad++; $display("FAIL fips_hold: got %h want %h", block_out, FIPS_PT); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] cts [3];
    logic [127:0] res; int dc, bc; logic bd;
    cts[0] = FIPS_CT; cts[1] = FIPS_CT ^ 128'h0; cts[2] = rand128();
    for (int i = 0; i < 3; i++) begin
      run_block(cts[i], res, dc, bc, bd);
      total++; if (dc != (NRND-1)*(SL+2)+SL+2) begin bad++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, dc, (NRND-1)*(SL+2)+SL+2); end
      total++; if (res !== aes_decrypt(cts[i])) begin bad++; $display("FAIL b2b_result[%0d]: got %h want %h", i, res, aes_decrypt(cts[i])); end
    end
    step();
  endtask

  task automatic test_hold_start();
    int exp_key[$];
    int dcs[$];
    logic [127:0] a, b, r1, r2;
    int lat, d0, d1;
    lat = (NRND-1)*(SL+2)+SL+2;
    a = rand128(); b = rand128(); r1 = '0; r2 = '0;
    exp_key.push_back(NRND);
    for (int r = NRND - 1; r >= 1; r--) repeat (SL + 2) exp_key.push_back(r);
    repeat (SL + 1) exp_key.push_back(0);
    exp_key.push_back(NRND);
    start = 1'b1; blk = a;
    total++; if (key_addr !== 4'(exp_key[0])) begin bad++; $display("FAIL hold_key_addr cycle 0: got %0d want %0d", key_addr, exp_key[0]); end
    for (int c = 1; c <= 2*lat + 5; c++) begin
      step();
      if (c == 2) blk = b;
      if (c == 2*lat - 1) start = 1'b0;
      if (c < exp_key.size()) begin
        total++;
        if (key_addr !== 4'(exp_key[c])) begin bad++; $display("FAIL hold_key_addr cycle %0d: got %0d want %0d", c, key_addr, exp_key[c]); end
      end
      if (done) begin
        dcs.push_back(c);
        if (dcs.size() == 1) r1 = block_out; else r2 = block_out;
      end
    end
    d0 = (dcs.size() > 0) ? dcs[0] : -1;
    d1 = (dcs.size() > 1) ? dcs[1] : -1;
    total++; if (dcs.size() != 2) begin bad++; $display("FAIL hold_result_count: got %0d want 2", dcs.size()); end
    total++; if (d0 != lat || d1 != 2*lat) begin bad++; $display("FAIL hold_done_cycles: got %0d,%0d want %0d,%0d", d0, d1, lat, 2*lat); end
    total++; if (r1 !== aes_decrypt(a)) begin bad++; $display("FAIL hold_result_a: got %h want %h", r1, aes_decrypt(a)); end
    total++; if (r2 !== aes_decrypt(b)) begin bad++; $display("FAIL hold_result_b: got %h want %h", r2, aes_decrypt(b)); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] res; int dc, bc; logic bd; int seen;
    start = 1'b1; blk = FIPS_CT;
    step();
    start = 1'b0;
    repeat (19) step();
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrst_flags: busy %b done %b want 0 0", busy, done); end
    total++; if (key_addr !== 4'(NRND)) begin bad++; $display("FAIL midrst_key_addr: got %0d want %0d", key_addr, NRND); end
    total++; if (block_out !== '0 || sub_in !== '0 || mix_in !== '0) begin
      bad++; $display("FAIL midrst_data: out %h sub %h mix %h want 0", block_out, sub_in, mix_in);
    end
    seen = 0;
    repeat (3) begin step(); if (done) seen++; end
    rst_n = 1'b1;
    run_block(FIPS_CT, res, dc, bc, bd);
    total++; if (seen != 0) begin bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", seen); end
    total++; if (dc != (NRND-1)*(SL+2)+SL+2 || res !== FIPS_PT) begin
      bad++; $display("FAIL midrst_restart: cycle %0d result %h want %0d %h", dc, res, (NRND-1)*(SL+2)+SL+2, FIPS_PT);
    end
    step();
  endtask

  task automatic test_random();
    logic [127:0] ct, res; int dc, bc; logic bd;
    expand_key(rand128());
    for (int n = 0; n < 4; n++) begin
      ct = rand128();
      repeat ($urandom_range(0, 3)) step();
      run_block(ct, res, dc, bc, bd);
      total++; if (res !== aes_decrypt(ct) || dc != (NRND-1)*(SL+2)+SL+2) begin
        bad++; $display("FAIL random[%0d]: got %h at cycle %0d want %h at %0d", n, res, dc, aes_decrypt(ct), (NRND-1)*(SL+2)+SL+2);
      end
    end
    step();
    expand_key(FIPS_KEY);
  endtask

  task automatic test_sub_lat3();
    int dc, bc; logic bd;
    start3 = 1'b1; blk3 = FIPS_CT;
    step();
    start3 = 1'b0;
    dc = 0; bc = 0; bd = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      if (done3) begin dc = c; bd = busy3; break; end
      if (busy3) bc++;
      step();
    end
    total++; if (bc != (NRND-1)*(SL3+2)+SL3+1) begin bad++; $display("FAIL lat3_busy_cycles: got %0d want %0d", bc, (NRND-1)*(SL3+2)+SL3+1); end
    total++; if (dc != (NRND-1)*(SL3+2)+SL3+2 || bd !== 1'b0) begin
      bad++; $display("FAIL lat3_done: cycle %0d busy %b want %0d 0", dc, bd, (NRND-1)*(SL3+2)+SL3+2);
    end
    total++; if (block_out3 !== FIPS_PT) begin bad++; $display("FAIL lat3_plaintext: got %h want %h", block_out3, FIPS_PT); end
  endtask

  initial begin
    start = 1'b0; start3 = 1'b0; blk = '0; blk3 = '0;
    build_sbox();
    expand_key(FIPS_KEY);
    test_reset();
    test_fips();
    test_back_to_back();
    test_hold_start();
    test_reset_mid();
    test_random();
    test_sub_lat3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_dec_round_ctrl.md
AES_DEC_ROUND_CTRL -- requirements
Module: aes_dec_round_ctrl

Interface
REQ-001 SHALL have parameter SUB_LAT, default 2: cycles from a stable oSubIn to a valid iSubOut in the external inverse SubBytes/ShiftRows stage.
REQ-002 SHALL have parameter NR, default 10: number of AES rounds (AES-128).
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port iStart, input, 1: request to decrypt iBlockIn.
REQ-006 SHALL have port iBlockIn, input, 128: ciphertext block, sampled on the accepted iStart.
REQ-007 SHALL have port oKeyAddr, output, 4: round-key index into the external key store.
REQ-008 SHALL have port iKeyData, input, 128: round key for oKeyAddr, valid in the same cycle (asynchronous read).
REQ-009 SHALL have port oSubIn, output, 128: state to the inverse SubBytes/ShiftRows stage.
REQ-010 SHALL have port iSubOut, input, 128: output of that stage.
REQ-011 SHALL have port oMixIn, output, 128: state to the external combinational InvMixColumns.
REQ-012 SHALL have port iMixOut, input, 128: InvMixColumns result, same cycle.
REQ-013 SHALL have port oBusy, output, 1: high while a block is in progress.
REQ-014 SHALL have port oDone, output, 1: one-cycle pulse when oBlockOut is valid.
REQ-015 SHALL have port oBlockOut, output, 128: plaintext, held until the next oDone.

Function
REQ-016 SHALL implement an FSM with states IDLE, SUB, MIX.
REQ-017 SHALL keep a 128-bit state register rState, a round counter rRound (4 bits) and a wait counter rWait (width ceil(log2(SUB_LAT+1)), minimum 1).
REQ-018 SHALL drive oKeyAddr = NR in IDLE, and drive oKeyAddr = rRound in SUB and MIX.
REQ-019 SHALL accept iStart only in IDLE. On the accepting edge: rState <= iBlockIn ^ iKeyData (key NR), rRound <= NR-1, rWait <= 0, next state SUB.
REQ-020 SHALL ignore iStart in SUB and MIX, with no queuing.
REQ-021 SHALL drive oSubIn = rState at all times, and SHALL NOT change rState during SUB.
REQ-022 In SUB, SHALL increment rWait each cycle until rWait == SUB_LAT.
REQ-023 In the SUB cycle with rWait == SUB_LAT, SHALL form iSubOut ^ iKeyData and clear rWait.
REQ-024 At that SUB_LAT point with rRound != 0, SHALL load the XOR result into rState and go to MIX.
REQ-025 At that SUB_LAT point with rRound == 0, SHALL load the XOR result into oBlockOut, pulse oDone high for the next cycle, and go to IDLE.
REQ-026 SHALL drive oMixIn = rState. MIX SHALL last 1 cycle: rState <= iMixOut, rRound <= rRound-1, next state SUB.
REQ-027 Per-block latency with default parameters:
- SUB lasts SUB_LAT+1 cycles; MIX lasts 1 cycle.
- Busy duration = (NR-1)*(SUB_LAT+2)+(SUB_LAT+1) = 39 cycles.
- oDone is high in cycle 40, where cycle 1 is the first after the accept edge.
REQ-028 SHALL drive oBusy = 1 exactly in SUB and MIX; oBusy SHALL be 0 in the oDone cycle.
REQ-029 SHALL accept an iStart asserted in the oDone cycle (back-to-back blocks, no bubble).
REQ-030 SHALL leave oBlockOut unchanged except on the round-0 capture.
REQ-031 SHALL NOT depend on values of iSubOut or iMixOut in cycles where they are not sampled (X-tolerant).

Reset
REQ-032 While rst_n = 0, SHALL immediately (asynchronously) force: state IDLE, rState = 0, rRound = 0, rWait = 0, oBlockOut = 0, oDone = 0, oBusy = 0, oKeyAddr = NR.
REQ-033 Reset asserted mid-block SHALL abort the block with no oDone pulse. The first edge after deassertion SHALL accept an iStart.

Verification
REQ-034 FIPS-197 C.1, single block:
- Stimulus: key 000102030405060708090a0b0c0d0e0f (bench supplies the expanded schedule), iBlockIn 69c4e0d86a7b0430d8cdb78070b4c55a.
- Response: oBlockOut 00112233445566778899aabbccddeeff, with oDone in cycle 40.
REQ-035 Back-to-back blocks:
- Stimulus: a second block (FIPS-197 C.1 ciphertext XORed with all-zero delta, then a random vector) started in the oDone cycle.
- Response: both results match the reference model; the second oDone arrives exactly 40 cycles after the first.
REQ-036 iStart held high during busy:
- Response: exactly one result per accepted start.
- Response: oKeyAddr sequence is 10, 9,9,9,9, 8..., 0,0,0.
REQ-037 Reset mid-block:
- Stimulus: rst_n low at cycle 20.
- Response: all outputs reset values within the same cycle, and no oDone.
- Response: a restart after deassertion produces the correct plaintext.
REQ-038 SUB_LAT = 3 build:
- Response: busy duration = 9*5+4 = 49 cycles.
- Response: FIPS-197 C.1 result is still correct.
